// File: rtl/store_queue_merge_pkg.sv
// Shared types for the store queue: word address/data types, the queue
// entry record, the drain FSM states and the wrapping pointer increment.
// Ports: none (package).
package store_queue_merge_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int NBYTES = 4;

   typedef logic [ADDR_W-1:0] waddr_t;
   typedef logic [DATA_W-1:0] w_t;
   typedef logic [NBYTES-1:0] mask_t;

   typedef struct packed {
      logic   valid;
      waddr_t addr;
      mask_t  mask;
      w_t     data;
   } stq_entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      COMMIT = 2'd3
   } drain_state_e;

   // Pointer increment for any depth: the last slot wraps to slot 0.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/store_queue_merge_if.sv
// Request/response bundle used on both sides of the store queue.
// Server: the side that receives requests (store queue facing the core).
// Client: the side that issues requests (store queue facing the L1D).
// Signals: req_valid, req_we, req_mask, req_addr, req_data, resp_ack, resp_data.
interface l1dcache_core_if;
   import store_queue_merge_pkg::*;

   logic   req_valid;
   logic   req_we;
   mask_t  req_mask;
   waddr_t req_addr;
   w_t     req_data;
   logic   resp_ack;
   w_t     resp_data;

   modport Server (
      input  req_valid, req_we, req_mask, req_addr, req_data,
      output resp_ack, resp_data
   );

   modport Client (
      output req_valid, req_we, req_mask, req_addr, req_data,
      input  resp_ack, resp_data
   );
endinterface

// File: rtl/store_queue_merge_fwd_merge.sv
// Combinational store-to-load forwarding over the queue contents.
// Walks the live entries from head (oldest) to youngest, so younger stores
// overwrite older bytes. Bytes nobody covers read as zero.
// Ports: entries/head/count (queue state), req_addr/req_mask (load),
//        fwd_data (forwarded bytes), covered (bytes supplied), full_cover.
module stq_fwd_merge
   import store_queue_merge_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  stq_entry_t       entries [DEPTH],
   input  logic [PTR_W-1:0] head,
   input  logic [CNT_W-1:0] count,
   input  waddr_t           req_addr,
   input  mask_t            req_mask,
   output w_t               fwd_data,
   output mask_t            covered,
   output logic             full_cover
);

   logic [PTR_W-1:0] idx_s;
   logic             hit_s;

   // Oldest-to-youngest overlay of every matching live entry.
   always_comb begin
      fwd_data = {DATA_W{1'b0}};
      covered  = {NBYTES{1'b0}};
      idx_s    = head;
      hit_s    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_s = (i < int'(count)) && entries[idx_s].valid && (entries[idx_s].addr == req_addr);
         for (int b = 0; b < NBYTES; b++) begin
            fwd_data[8*b +: 8] = (hit_s && entries[idx_s].mask[b]) ?
                                 entries[idx_s].data[8*b +: 8] : fwd_data[8*b +: 8];
            covered[b]         = covered[b] | (hit_s & entries[idx_s].mask[b]);
         end
         idx_s = PTR_W'(ptr_inc(32'(idx_s), DEPTH));
      end
      full_cover = ((covered & req_mask) == req_mask);
   end

endmodule

// File: rtl/store_queue_merge.sv
// Store queue between the core load/store port and the L1D port.
// Loads pass straight through to the cache and are answered one cycle later
// with queued store bytes merged over the cache data. Stores are buffered and
// drained one at a time in non-load cycles by a four-state drain FSM.
// Optional feature: STQ_COALESCE_EN merges a store into the youngest entry
// when the addresses match and that entry is not being drained.
// Ports: clk, rst (async active-high), core (Server), cache (Client),
//        empty (no entries and FSM idle), count (valid entries).
module store_queue_merge
   import store_queue_merge_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   l1dcache_core_if.Server  core,
   l1dcache_core_if.Client  cache,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   stq_entry_t       entries_r [DEPTH];
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;
   drain_state_e     state_r;
   logic             load_pend_r;
   logic             full_r;
   logic             store_ack_r;
   w_t               fwd_data_r;
   mask_t            covered_r;

   w_t    fwd_data_s;
   mask_t covered_s;
   logic  full_cover_s;
   logic  is_load_s;
   logic  is_store_s;
   logic  commit_pop_s;
   logic  issue_s;
   logic  coalesce_s;
   logic  accept_s;
   logic  alloc_s;
   w_t    merged_s;
`ifdef STQ_COALESCE_EN
   logic [PTR_W-1:0] youngest_s;
   stq_entry_t       coal_entry_s;
`endif

   stq_fwd_merge #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_fwd (
      .entries   (entries_r),
      .head      (head_r),
      .count     (count_r),
      .req_addr  (core.req_addr),
      .req_mask  (core.req_mask),
      .fwd_data  (fwd_data_s),
      .covered   (covered_s),
      .full_cover(full_cover_s)
   );

   // Request classification and store acceptance.
   always_comb begin
      is_load_s    = core.req_valid && !core.req_we;
      is_store_s   = core.req_valid && core.req_we;
      commit_pop_s = (state_r == COMMIT) && !is_load_s;
      issue_s      = (state_r == ISSUE) && !is_load_s;
`ifdef STQ_COALESCE_EN
      youngest_s   = (tail_r == {PTR_W{1'b0}}) ? PTR_W'(DEPTH - 1) : tail_r - PTR_W'(1);
      // The head is frozen once the drain FSM has started on it.
      coalesce_s   = is_store_s && (count_r != {CNT_W{1'b0}}) &&
                     entries_r[youngest_s].valid &&
                     (entries_r[youngest_s].addr == core.req_addr) &&
                     !((youngest_s == head_r) && (state_r != IDLE));
      coal_entry_s       = entries_r[youngest_s];
      coal_entry_s.mask  = entries_r[youngest_s].mask | core.req_mask;
      for (int b = 0; b < NBYTES; b++) begin
         coal_entry_s.data[8*b +: 8] = core.req_mask[b] ? core.req_data[8*b +: 8] :
                                       entries_r[youngest_s].data[8*b +: 8];
      end
`else
      coalesce_s   = 1'b0;
`endif
      // A pop in the same cycle frees the slot the new store takes.
      accept_s     = is_store_s && (coalesce_s || (count_r < CNT_W'(DEPTH)) || commit_pop_s);
      alloc_s      = accept_s && !coalesce_s;
   end

   // Cache port: loads pass through, otherwise the head store when issuing.
   always_comb begin
      if (is_load_s) begin
         cache.req_valid = 1'b1;
         cache.req_we    = 1'b0;
         cache.req_addr  = core.req_addr;
         cache.req_mask  = core.req_mask;
         cache.req_data  = {DATA_W{1'b0}};
      end else if (issue_s) begin
         cache.req_valid = 1'b1;
         cache.req_we    = 1'b1;
         cache.req_addr  = entries_r[head_r].addr;
         cache.req_mask  = entries_r[head_r].mask;
         cache.req_data  = entries_r[head_r].data;
      end else begin
         cache.req_valid = 1'b0;
         cache.req_we    = 1'b0;
         cache.req_addr  = {ADDR_W{1'b0}};
         cache.req_mask  = {NBYTES{1'b0}};
         cache.req_data  = {DATA_W{1'b0}};
      end
   end

   // Core response: forwarded bytes override cache bytes; full cover needs no cache ack.
   always_comb begin
      for (int b = 0; b < NBYTES; b++) begin
         merged_s[8*b +: 8] = covered_r[b] ? fwd_data_r[8*b +: 8] : cache.resp_data[8*b +: 8];
      end
      if (load_pend_r) begin
         core.resp_ack  = full_r | cache.resp_ack;
         core.resp_data = full_r ? fwd_data_r : merged_s;
      end else begin
         core.resp_ack  = store_ack_r;
         core.resp_data = {DATA_W{1'b0}};
      end
      empty = (count_r == {CNT_W{1'b0}}) && (state_r == IDLE);
      count = count_r;
   end

   // Queue storage, pointers, occupancy, drain FSM and registered response flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_r[i] <= '0;
         end
         head_r      <= {PTR_W{1'b0}};
         tail_r      <= {PTR_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         state_r     <= IDLE;
         load_pend_r <= 1'b0;
         full_r      <= 1'b0;
         store_ack_r <= 1'b0;
         fwd_data_r  <= {DATA_W{1'b0}};
         covered_r   <= {NBYTES{1'b0}};
      end else begin
         load_pend_r <= is_load_s;
         store_ack_r <= accept_s;
         if (is_load_s) begin
            fwd_data_r <= fwd_data_s;
            covered_r  <= covered_s;
            full_r     <= full_cover_s;
         end
         // Pop before write: when full, the new store reuses the popped slot.
         if (commit_pop_s) begin
            entries_r[head_r].valid <= 1'b0;
            head_r                  <= PTR_W'(ptr_inc(32'(head_r), DEPTH));
         end
         if (alloc_s) begin
            entries_r[tail_r] <= '{valid: 1'b1, addr: core.req_addr,
                                   mask: core.req_mask, data: core.req_data};
            tail_r            <= PTR_W'(ptr_inc(32'(tail_r), DEPTH));
         end
`ifdef STQ_COALESCE_EN
         if (coalesce_s) begin
            entries_r[youngest_s] <= coal_entry_s;
         end
`endif
         case ({alloc_s, commit_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         case (state_r)
            IDLE:    state_r <= (count_r != {CNT_W{1'b0}}) ? ISSUE : IDLE;
            ISSUE:   state_r <= is_load_s ? ISSUE : WAIT;
            WAIT:    state_r <= cache.resp_ack ? COMMIT : ISSUE;
            COMMIT:  state_r <= is_load_s ? COMMIT : IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_queue_merge.sv
// Self-checking bench for store_queue_merge (DEPTH=5). A driver issues one
// request per cycle and pushes the expected response; a monitor pops and
// compares. The reference is a list of accepted stores overlaid on a memory.
module tb_store_queue_merge;
   import store_queue_merge_pkg::*;

   localparam int DEPTH   = 5;
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int K_NONE  = 0;
   localparam int K_LOAD  = 1;
   localparam int K_STORE = 2;

   typedef struct {
      int     kind;
      waddr_t addr;
      mask_t  mask;
      w_t     data;
      w_t     exp_data;
      logic   exp_ack;
      logic   chk_ack;
   } item_t;

   typedef struct {
      waddr_t addr;
      mask_t  mask;
      w_t     data;
   } st_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             empty;
   logic [CNT_W-1:0] count;

   l1dcache_core_if core ();
   l1dcache_core_if cache ();

   store_queue_merge #(.DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .core (core),
      .cache(cache),
      .empty(empty),
      .count(count)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_fail   = 0;
   item_t sbq[$];
   st_t   mq[$];
   w_t    mem [waddr_t];
   int    st_ack_mode = 0;   // 0 never, 1 always, 2 random
   logic  load_ack_en = 1'b1;
   logic  last_store_ack = 1'b0;
   int    st_issues = 0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic w_t mem_rd(input waddr_t a);
      return mem.exists(a) ? mem[a] : {16'hC0DE, a[15:0]};
   endfunction

   function automatic w_t bm(input mask_t m);
      return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

   // Reference: memory word with every outstanding store overlaid in age order.
   function automatic void model_load(input waddr_t a, output w_t d, output mask_t cov);
      d   = mem_rd(a);
      cov = 4'b0000;
      foreach (mq[i]) begin
         if (mq[i].addr == a) begin
            d   = (d & ~bm(mq[i].mask)) | (mq[i].data & bm(mq[i].mask));
            cov = cov | mq[i].mask;
         end
      end
   endfunction

   task automatic drive(input int kind, input waddr_t a, input mask_t m, input w_t d,
                        input logic chk_ack, input logic exp_ack);
      item_t it;
      w_t    ed;
      mask_t cov;
      @(posedge clk);
      #3;
      core.req_valid = (kind != K_NONE);
      core.req_we    = (kind == K_STORE);
      core.req_addr  = a;
      core.req_mask  = m;
      core.req_data  = d;
      it.kind = kind; it.addr = a; it.mask = m; it.data = d;
      it.chk_ack = chk_ack; it.exp_ack = exp_ack; it.exp_data = 32'h0;
      if (kind == K_LOAD) begin
         model_load(a, ed, cov);
         it.exp_data = ed;
         it.exp_ack  = load_ack_en ? 1'b1 : ((cov & m) == m);
      end
      sbq.push_back(it);
   endtask

   task automatic idle();
      drive(K_NONE, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic drain_all(input string name);
      st_ack_mode = 1;
      for (int k = 0; k < 100 && !empty; k++) idle();
      idle();
      check({name, "_empty"}, {71'h0, empty}, 72'h1);
      check({name, "_count"}, 72'(count), 72'h0);
`ifndef STQ_COALESCE_EN
      check({name, "_model"}, 72'(mq.size()), 72'h0);
`endif
   endtask

   // Monitor: one scoreboard item per cycle, compared after the edge.
   initial begin
      item_t it;
      forever begin
         @(posedge clk);
         #2;
         if (sbq.size() > 0) begin
            it = sbq.pop_front();
            case (it.kind)
               K_STORE: begin
                  last_store_ack = core.resp_ack;
                  if (it.chk_ack) check("store_ack", {71'h0, core.resp_ack}, {71'h0, it.exp_ack});
                  if (core.resp_ack) mq.push_back('{it.addr, it.mask, it.data});
               end
               K_LOAD: begin
                  check("load_ack", {71'h0, core.resp_ack}, {71'h0, it.exp_ack});
                  check("load_data", 72'(core.resp_data & bm(it.mask)), 72'(it.exp_data & bm(it.mask)));
               end
               default: check("idle_ack", {71'h0, core.resp_ack}, 72'h0);
            endcase
         end
      end
   end

   // Cache model: capture at negedge, answer one cycle later.
   initial begin
      logic   cv, cwe, ack;
      waddr_t ca;
      mask_t  cm;
      w_t     cd;
      st_t    s;
      cache.resp_ack  = 1'b0;
      cache.resp_data = 32'h0;
      forever begin
         @(negedge clk);
         cv = cache.req_valid; cwe = cache.req_we; ca = cache.req_addr;
         cm = cache.req_mask;  cd = cache.req_data;
         @(posedge clk);
         #1;
         cache.resp_ack  = 1'b0;
         cache.resp_data = 32'h0;
         if (cv && !cwe) begin
            cache.resp_ack  = load_ack_en;
            cache.resp_data = mem_rd(ca);
         end else if (cv && cwe) begin
            st_issues++;
            ack = (st_ack_mode == 1) || (st_ack_mode == 2 && $urandom_range(0, 1) == 1);
            cache.resp_ack = ack;
            if (ack) begin
               mem[ca] = (mem_rd(ca) & ~bm(cm)) | (cd & bm(cm));
`ifndef STQ_COALESCE_EN
               if (mq.size() == 0) begin
                  check("drain_unexpected", {40'h0, ca}, 72'hFFFF_FFFF_FF);
               end else begin
                  s = mq.pop_front();
                  check("drain_entry", {ca, cm, cd}, {s.addr, s.mask, s.data});
               end
`endif
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic got;
      int   st0;
      rst = 1'b1;
      core.req_valid = 1'b0; core.req_we = 1'b0; core.req_addr = 32'h0;
      core.req_mask = 4'h0;  core.req_data = 32'h0;
      repeat (2) @(posedge clk);
      #3;
      check("rst_count", 72'(count), 72'h0);
      check("rst_empty", {71'h0, empty}, 72'h1);
      check("rst_resp_ack", {71'h0, core.resp_ack}, 72'h0);
      check("rst_resp_data", 72'(core.resp_data), 72'h0);
      check("rst_cache_valid", {71'h0, cache.req_valid}, 72'h0);
      rst = 1'b0;

      // Fill to DEPTH with the drain blocked, then a rejected store.
      st_ack_mode = 0;
      for (int i = 0; i < 5; i++) drive(K_STORE, 32'h10 + 32'(i), 4'hF, 32'hA000_0000 + 32'(i), 1'b1, 1'b1);
      drive(K_STORE, 32'h15, 4'hF, 32'h6666_0006, 1'b1, 1'b0);
      idle();
      check("full_count", 72'(count), 72'h5);
      idle();
      st_ack_mode = 1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         drive(K_STORE, 32'h15, 4'hF, 32'h6666_0006, 1'b0, 1'b0);
         idle();
         got = last_store_ack;
      end
      check("retry_accept", {71'h0, got}, 72'h1);
      drive(K_LOAD, 32'h15, 4'hF, 32'h0, 1'b0, 1'b0);
      drain_all("fill_drain");

      // Youngest store wins per byte, full cover without a cache ack.
      st_ack_mode = 0;
      load_ack_en = 1'b0;
      drive(K_STORE, 32'h10, 4'b0011, 32'hAAAA_1111, 1'b1, 1'b1);
      drive(K_STORE, 32'h10, 4'b0010, 32'h0000_2200, 1'b1, 1'b1);
      drive(K_LOAD, 32'h10, 4'b0011, 32'h0, 1'b0, 1'b0);
      drive(K_LOAD, 32'h10, 4'b0111, 32'h0, 1'b0, 1'b0);
      idle();
      load_ack_en = 1'b1;
      drain_all("merge_drain");

      // Partial overlap merged over cache data.
      st_ack_mode = 0;
      mem[32'h20] = 32'hDEAD_BEEF;
      drive(K_STORE, 32'h20, 4'b0001, 32'h0000_0055, 1'b1, 1'b1);
      drive(K_LOAD, 32'h20, 4'b1111, 32'h0, 1'b0, 1'b0);
      drain_all("partial_drain");

      // Loads hold the drain in ISSUE; the store goes out in the first idle cycle.
      st_ack_mode = 1;
      drive(K_STORE, 32'h40, 4'hF, 32'h1234_5678, 1'b1, 1'b1);
      st0 = st_issues;
      for (int i = 0; i < 6; i++) drive(K_LOAD, 32'h40, 4'hF, 32'h0, 1'b0, 1'b0);
      idle();
      check("no_issue_during_loads", 72'(st_issues), 72'(st0));
      check("burst_count", 72'(count), 72'h1);
      idle();
      check("issue_first_idle", 72'(st_issues), 72'(st0 + 1));
      idle();
      check("commit_count", 72'(count), 72'h1);
      check("commit_empty", {71'h0, empty}, 72'h0);
      idle();
      check("pop_count", 72'(count), 72'h0);
      check("pop_empty", {71'h0, empty}, 72'h1);

      // Asynchronous reset in the middle of WAIT.
      st_ack_mode = 0;
      for (int i = 0; i < 3; i++) drive(K_STORE, 32'h60 + 32'(i), 4'hF, $urandom, 1'b1, 1'b1);
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         idle();
         got = cache.req_valid && cache.req_we;
      end
      check("reach_issue", {71'h0, got}, 72'h1);
      idle();
      check("pre_rst_count", 72'(count), 72'h3);
      rst = 1'b1;
      #1;
      check("async_rst_count", 72'(count), 72'h0);
      check("async_rst_empty", {71'h0, empty}, 72'h1);
      check("async_rst_cache_valid", {71'h0, cache.req_valid}, 72'h0);
      mq.delete();
      idle();
      rst = 1'b0;
      idle();

`ifdef STQ_COALESCE_EN
      // Back-to-back stores to one address share a slot.
      st_ack_mode = 0;
      load_ack_en = 1'b0;
      drive(K_STORE, 32'h30, 4'b0001, 32'h0000_00AA, 1'b1, 1'b1);
      drive(K_STORE, 32'h30, 4'b0100, 32'h00CC_0000, 1'b1, 1'b1);
      idle();
      check("coalesce_count", 72'(count), 72'h1);
      drive(K_LOAD, 32'h30, 4'b0101, 32'h0, 1'b0, 1'b0);
      idle();
      load_ack_en = 1'b1;
      drain_all("coalesce_drain");
`endif

      // Random traffic over a small address window.
      st_ack_mode = 2;
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 3))
            0:       idle();
            1:       drive(K_LOAD, 32'h50 + 32'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), 32'h0, 1'b0, 1'b0);
            default: drive(K_STORE, 32'h50 + 32'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), $urandom, 1'b0, 1'b0);
         endcase
      end
      drain_all("random_drain");
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
